// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial 2-bit-per-cycle adder controller.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int CHUNK = 2;

   // Chunk index width: $clog2(width/CHUNK), never narrower than one bit.
   function automatic int cnt_w(input int width);
      int w;
      w = $clog2(width / CHUNK);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/two_bit_adder_cin.sv
// Shared 2-bit adder slice with carry in/out.
// Latency: combinational. Backpressure: none.
module two_bit_adder_cin (
   input  logic [1:0] x,
   input  logic [1:0] y,
   input  logic       cin,
   output logic [1:0] z,
   output logic       carry
);

   logic [2:0] s;

   assign s     = {1'b0, x} + {1'b0, y} + {2'b00, cin};
   assign z     = s[1:0];
   assign carry = s[2];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial WIDTH-bit adder reusing one 2-bit slice, LS chunk first; SERIAL_ADDER_OVF_EN adds ovf.
// Latency: WIDTH/2 cycles from accepted start to done; one result per WIDTH/2+1 cycles.
// Backpressure: start is accepted only when not busy; start during RUN is ignored.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH / CHUNK - 1);

   state_t           state, nxt;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
   logic             carry;
   logic [1:0]       z;
   logic             co;

   two_bit_adder_cin u_slice (
      .x     (opa[1:0]),
      .y     (opb[1:0]),
      .cin   (carry),
      .z     (z),
      .carry (co)
   );

   // New chunk enters at the top; after WIDTH/2 shifts acc holds the full sum.
   assign acc_nxt = WIDTH'({z, acc} >> CHUNK);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt  = state;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: if (start) nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (idx == LAST) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = start ? RUN : IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else if (state != RUN) begin
         if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= 1'b0;
            idx   <= '0;
         end
      end else begin
         opa   <= opa >> CHUNK;
         opb   <= opb >> CHUNK;
         acc   <= acc_nxt;
         carry <= co;
         idx   <= idx + CW'(1);
         if (idx == LAST) begin
            sum  <= acc_nxt;
            cout <= co;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit.
            ovf  <= co ^ (z[1] ^ opa[1] ^ opb[1]);
`endif
         end
      end
   end

endmodule
